i2s_tx: RTL
===========

Name: i2s_tx

Overview:
- I2S transmitter that serializes equalized stereo samples from the EQ engine output to the codec DAC.
- Generates the SCLK and LRCLK bit clocks from the system clock.
- Holds one pending sample pair in a buffer.
- Requests a new pair once per frame and reports underrun and overrun.
- Sits between the EQ engine outputs and the codec pins.

Parameters:
- SCLK_DIV, 8: system clocks per SCLK half-period (SCLK = clk/(2*SCLK_DIV)); must be ≥2.
- DATA_W, 16: sample width; each channel slot is 32 SCLKs.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- lft_smpl  input  DATA_W  left sample, signed.
- rght_smpl  input  DATA_W  right sample, signed.
- vld  input  1  single-cycle strobe: lft_smpl/rght_smpl are a new pair.
- SCLK  output  1  serial bit clock to codec.
- LRCLK  output  1  word select; 0 = left, 1 = right.
- SDout  output  1  serial data, MSB first.
- smpl_req  output  1  one-clk pulse at each frame load; upstream should supply the next pair.
- undr  output  1  one-clk pulse: frame loaded with no new pair.
- ovr  output  1  one-clk pulse: pending pair overwritten before it was consumed.

Behaviour:
- Interface is fixed: one clock (clk); reset rst is asynchronous and active-high.
- Reset: SCLK=0, LRCLK=0, SDout=0, smpl_req=0, undr=0, ovr=0, clk_cnt=0, bit_cnt=0, frame shift reg=0, current pair=0, pend_vld=0. Reset asserted mid-frame aborts immediately; no partial frame resumes.
- Clock divider: clk_cnt counts 0..SCLK_DIV-1. When clk_cnt==SCLK_DIV-1, SCLK toggles and clk_cnt wraps.
  - First SCLK rise occurs SCLK_DIV clks after reset release.
  - SCLK 1→0 is the "fall event".
- bit_cnt (6 bits) increments on each fall event and wraps 63→0.
  - Frame = 64 SCLK = 128*SCLK_DIV clks (1024 clks by default).
- LRCLK, SDout and bit_cnt update on the same clk edge as the fall event. LRCLK = new bit_cnt[5]. The codec samples SDout on SCLK rise.
- Frame load happens on the fall event where bit_cnt wraps 63→0. On that edge:
  - Load F = {cur_l, 16'h0, cur_r, 16'h0}, where cur is selected per the buffer rules below.
  - Pulse smpl_req for 1 clk.
  - The first load after reset occurs at the 64th fall event, so the first frame after reset transmits zeros.
- SDout in bit slot k:
  - k = 0: 0.
  - k = 1..63: F[64-k].
  - Gives I2S one-bit delay: left MSB at k=1, left LSB at k=16, right MSB at k=33, right LSB at k=48. All other slots are 0.
- Buffer rules (evaluated every clk):
  - vld and not a load cycle: pend ← inputs; pend_vld ← 1. If pend_vld was already 1, pulse ovr.
  - Load cycle, pend_vld=1: cur ← pend. If vld the same cycle, pend ← inputs and pend_vld stays 1 (no ovr); otherwise pend_vld ← 0.
  - Load cycle, pend_vld=0, vld=1: bypass, cur ← inputs; pend_vld stays 0; no undr.
  - Load cycle, pend_vld=0, vld=0: cur retains the previous pair, so the last pair repeats; pulse undr.
- Arithmetic: samples pass bit-exact (two's complement); no scaling or saturation. Only DATA_W=16 is required to be supported.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset release, no vld: SCLK period = 16 clks. LRCLK is low for 512 clks then high for 512. SDout stays 0. First smpl_req at clk 1024. undr pulses with every smpl_req.
- Pair lft=16'hA5C3, rght=16'h8001 with vld before the first load: during the second frame SDout bits k=1..16 = A5C3 MSB-first, k=33..48 = 8001, all other slots 0. LRCLK rises at the start of k=32. No undr on that load.
- Two vld pulses between loads (16'h1111/16'h2222 then 16'h3333/16'h4444): ovr pulses once on the second vld. The next frame transmits 3333/4444.
- vld (16'h7FFF/16'h8000) on exactly the load cycle with pend empty: bypass; the frame carries 7FFF/8000; undr stays 0; pend_vld stays 0.
- After a frame of 1234/5678, no further vld: the next frame repeats 1234/5678 and undr pulses at its load.
- Assert rst at bit_cnt=20 mid-frame: all outputs 0 the same clk (async). After release, timing restarts as in the first scenario.

Source files
------------

// File: rtl/i2s_tx.sv
// I2S transmitter: divides clk down to SCLK, frames stereo samples into 64-bit
// I2S frames (one-bit delay, MSB first) and buffers one pending sample pair.
module i2s_tx #(
   parameter int unsigned SCLK_DIV = 8,
   parameter int unsigned DATA_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] lft_smpl,
   input  logic [DATA_W-1:0] rght_smpl,
   input  logic              vld,
   output logic              SCLK,
   output logic              LRCLK,
   output logic              SDout,
   output logic              smpl_req,
   output logic              undr,
   output logic              ovr
);

   localparam int unsigned CntW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam int unsigned PadW = 32 - DATA_W;
   localparam logic [CntW-1:0] CntMax = CntW'(SCLK_DIV - 1);

   logic [CntW-1:0]   clk_cnt_q, clk_cnt_d;
   logic              sclk_q, sclk_d;
   logic [5:0]        bit_cnt_q, bit_cnt_d;
   logic              lrclk_q, lrclk_d;
   logic              sdout_q, sdout_d;
   logic [63:0]       shift_q, shift_d;
   logic [DATA_W-1:0] cur_l_q, cur_l_d, cur_r_q, cur_r_d;
   logic [DATA_W-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
   logic              pend_vld_q, pend_vld_d;
   logic              smpl_req_q, smpl_req_d;
   logic              undr_q, undr_d;
   logic              ovr_q, ovr_d;

   logic tick, fall, load;

   // SCLK divider; a fall event is the tick that takes SCLK from 1 to 0
   always_comb begin
      tick      = (clk_cnt_q == CntMax);
      fall      = tick && sclk_q;
      load      = fall && (bit_cnt_q == 6'd63);
      clk_cnt_d = tick ? '0 : clk_cnt_q + CntW'(1);
      sclk_d    = tick ? ~sclk_q : sclk_q;
   end

   // Pending-pair buffer and selection of the pair for the next frame
   always_comb begin
      cur_l_d    = cur_l_q;
      cur_r_d    = cur_r_q;
      pend_l_d   = pend_l_q;
      pend_r_d   = pend_r_q;
      pend_vld_d = pend_vld_q;
      undr_d     = 1'b0;
      ovr_d      = 1'b0;
      if (load) begin
         if (pend_vld_q) begin
            cur_l_d = pend_l_q;
            cur_r_d = pend_r_q;
            if (vld) begin
               pend_l_d = lft_smpl;
               pend_r_d = rght_smpl;
            end else begin
               pend_vld_d = 1'b0;
            end
         end else if (vld) begin
            // Bypass: pair arrives on the load cycle itself, pend stays empty
            cur_l_d = lft_smpl;
            cur_r_d = rght_smpl;
         end else begin
            // Nothing new: cur keeps the old pair so it repeats
            undr_d = 1'b1;
         end
      end else if (vld) begin
         pend_l_d   = lft_smpl;
         pend_r_d   = rght_smpl;
         pend_vld_d = 1'b1;
         ovr_d      = pend_vld_q;
      end
   end

   // Serializer: slot 0 of each frame is the I2S one-bit delay, then F MSB first
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      lrclk_d    = lrclk_q;
      sdout_d    = sdout_q;
      shift_d    = shift_q;
      smpl_req_d = load;
      if (fall) begin
         bit_cnt_d = bit_cnt_q + 6'd1;
         lrclk_d   = bit_cnt_d[5];
         if (load) begin
            shift_d = {cur_l_d, {PadW{1'b0}}, cur_r_d, {PadW{1'b0}}};
            sdout_d = 1'b0;
         end else begin
            sdout_d = shift_q[63];
            shift_d = {shift_q[62:0], 1'b0};
         end
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_cnt_q  <= '0;
         sclk_q     <= 1'b0;
         bit_cnt_q  <= '0;
         lrclk_q    <= 1'b0;
         sdout_q    <= 1'b0;
         shift_q    <= '0;
         cur_l_q    <= '0;
         cur_r_q    <= '0;
         pend_l_q   <= '0;
         pend_r_q   <= '0;
         pend_vld_q <= 1'b0;
         smpl_req_q <= 1'b0;
         undr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         clk_cnt_q  <= clk_cnt_d;
         sclk_q     <= sclk_d;
         bit_cnt_q  <= bit_cnt_d;
         lrclk_q    <= lrclk_d;
         sdout_q    <= sdout_d;
         shift_q    <= shift_d;
         cur_l_q    <= cur_l_d;
         cur_r_q    <= cur_r_d;
         pend_l_q   <= pend_l_d;
         pend_r_q   <= pend_r_d;
         pend_vld_q <= pend_vld_d;
         smpl_req_q <= smpl_req_d;
         undr_q     <= undr_d;
         ovr_q      <= ovr_d;
      end
   end

   assign SCLK     = sclk_q;
   assign LRCLK    = lrclk_q;
   assign SDout    = sdout_q;
   assign smpl_req = smpl_req_q;
   assign undr     = undr_q;
   assign ovr      = ovr_q;

endmodule
